led_scan: RTL



---
 rtl/led_pkg.sv | 19 +
 rtl/slot_timer.sv | 34 +++
 rtl/led_scan.sv | 105 ++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the 7-segment anode scanner: FSM states, the
// all-off anode pattern and the slot-index to active-low anode decode.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] AN_OFF = 4'b1111;

    function automatic logic [3:0] an_decode(input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Slot timer: counts the cycles of one digit slot and strobes the last DRIVE
// cycle and the last cycle of the whole slot. It holds at zero while stopped.
module slot_timer #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic drive_done,
    output logic slot_done
);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || slot_done) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // With no blanking both strobes fire together and the FSM gives slot_done priority.
    assign drive_done = run && (count == DRIVE_LAST);
    assign slot_done  = run && (count == SLOT_LAST);

endmodule

// File: rtl/led_scan.sv
// Time-multiplexed anode scanner for a 4-digit common-anode display: one digit
// per slot, a blanking gap at the end of each slot, and per-digit masking.
module led_scan
    import led_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] digit_mask,
    output logic [3:0] an,
    output logic [1:0] slot_idx,
    output logic       frame_tick
);

    state_t     state, state_nxt;
    logic [3:0] mask_q, mask_nxt;
    logic [3:0] an_nxt;
    logic [1:0] slot_nxt;
    logic [1:0] next_idx;
    logic       tick_nxt;
    logic       run;
    logic       drive_done;
    logic       slot_done;

    assign run      = en && (state != IDLE);
    assign next_idx = slot_idx + 2'd1;

    slot_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .drive_done(drive_done),
        .slot_done (slot_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            an         <= AN_OFF;
            slot_idx   <= 2'd0;
            frame_tick <= 1'b0;
            mask_q     <= 4'b0000;
        end else begin
            state      <= state_nxt;
            an         <= an_nxt;
            slot_idx   <= slot_nxt;
            frame_tick <= tick_nxt;
            mask_q     <= mask_nxt;
        end
    end

    // The mask is only resampled at slot boundaries, so a masked slot still takes its full time.
    always_comb begin
        state_nxt = state;
        an_nxt    = an;
        slot_nxt  = slot_idx;
        mask_nxt  = mask_q;
        tick_nxt  = 1'b0;

        if (!en) begin
            state_nxt = IDLE;
            an_nxt    = AN_OFF;
            slot_nxt  = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = DRIVE;
                    slot_nxt  = 2'd0;
                    mask_nxt  = digit_mask;
                    an_nxt    = digit_mask[0] ? an_decode(2'd0) : AN_OFF;
                end
                DRIVE, GAP: begin
                    if (slot_done) begin
                        state_nxt = DRIVE;
                        slot_nxt  = next_idx;
                        mask_nxt  = digit_mask;
                        an_nxt    = digit_mask[next_idx] ? an_decode(next_idx) : AN_OFF;
                        tick_nxt  = (slot_idx == 2'd3);
                    end else if (state == DRIVE && drive_done) begin
                        state_nxt = GAP;
                        an_nxt    = AN_OFF;
                    end else if (state == DRIVE) begin
                        an_nxt = mask_q[slot_idx] ? an_decode(slot_idx) : AN_OFF;
                    end else begin
                        an_nxt = AN_OFF;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    an_nxt    = AN_OFF;
                    slot_nxt  = 2'd0;
                end
            endcase
        end
    end

endmodule
